adder_sweep_checker: RTL and testbench

- Synthesizable, self-running exhaustive checker for the 4-bit ripple-carry adder block; drives a, b and cin into it and checks s and cout.
- Sweeps cin in {0,1}, a in 0..MAX_A and b in 0..MAX_B, and compares the adder outputs against an internal a+b+cin reference.
- Reports pass/fail, a saturating error count and the first failing vector.
- Sits on the board next to the adder under test, replacing the simulation-only stimulus bench so the same check runs in hardware.

---
 rtl/adder_chk_pkg.sv | 8 +
 rtl/adder_sweep_checker_sweep_gen.sv | 39 +++
 rtl/adder_sweep_checker.sv | 118 +++++++++++
 tb/tb_adder_sweep_checker.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_chk_pkg.sv
// adder_chk_pkg: shared FSM states, error-count limit and sweep length for the adder sweep checker
package adder_chk_pkg;
  typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;
  localparam int ERR_CNT_MAX = 255;
  function automatic int n_vectors(input int max_a, input int max_b);
    return (max_a + 1) * (max_b + 1) * 2;
  endfunction
endpackage

// File: rtl/adder_sweep_checker_sweep_gen.sv
// operand_sweep_gen: nested b/a/cin operand counters, b innermost, cin outermost
module operand_sweep_gen #(
  parameter int WIDTH = 4,
  parameter int MAX_A = 9,
  parameter int MAX_B = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_step,
  output logic [WIDTH-1:0] o_a,
  output logic [WIDTH-1:0] o_b,
  output logic             o_cin,
  output logic             o_last
);
  localparam logic [WIDTH-1:0] LA = WIDTH'(MAX_A);
  localparam logic [WIDTH-1:0] LB = WIDTH'(MAX_B);
  logic [WIDTH-1:0] r_a, r_b;
  logic r_cin;
  logic w_a_end, w_b_end;
  assign w_a_end = r_a == LA;
  assign w_b_end = r_b == LB;
  assign o_last = w_a_end && w_b_end && r_cin;
  assign o_a = r_a;
  assign o_b = r_b;
  assign o_cin = r_cin;
  // stepping past the final vector is a no-op so operands hold in DONE
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_a <= '0;
      r_b <= '0;
      r_cin <= 1'b0;
    end else if (i_step && !o_last) begin
      r_b <= w_b_end ? '0 : r_b + 1'b1;
      r_a <= !w_b_end ? r_a : w_a_end ? '0 : r_a + 1'b1;
      r_cin <= r_cin | (w_a_end && w_b_end);
    end
  end
endmodule

// File: rtl/adder_sweep_checker.sv
// adder_sweep_checker: self-running exhaustive checker driving and verifying a WIDTH-bit adder
module adder_sweep_checker import adder_chk_pkg::*; #(
  parameter int WIDTH  = 4,
  parameter int MAX_A  = 9,
  parameter int MAX_B  = 9,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic             cin_o,
  input  logic [WIDTH-1:0] s_i,
  input  logic             cout_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       err_cnt,
  output logic [15:0]      vec_cnt,
  output logic             first_err_valid,
  output logic [WIDTH-1:0] first_err_a,
  output logic [WIDTH-1:0] first_err_b,
  output logic             first_err_cin
);
  localparam int SW = SETTLE > 1 ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [15:0] N_VEC = 16'(n_vectors(MAX_A, MAX_B));
  state_t r_state;
  logic [SW-1:0] r_settle;
  logic r_busy, r_done, r_pass, r_fev, r_fe_cin;
  logic [7:0] r_err_cnt;
  logic [15:0] r_vec_cnt;
  logic [WIDTH-1:0] r_fe_a, r_fe_b;
  logic [WIDTH-1:0] w_a, w_b;
  logic w_cin, w_last, w_start, w_miss;
  logic [WIDTH:0] w_ref;
  logic [7:0] w_err_nxt;
  assign w_start = start && (r_state == IDLE || r_state == DONE);
  assign w_ref = {1'b0, w_a} + {1'b0, w_b} + {{WIDTH{1'b0}}, w_cin};
  assign w_miss = w_ref != {cout_i, s_i};
  assign w_err_nxt = (w_miss && r_err_cnt != 8'(ERR_CNT_MAX)) ? r_err_cnt + 8'd1 : r_err_cnt;
  operand_sweep_gen #(.WIDTH(WIDTH), .MAX_A(MAX_A), .MAX_B(MAX_B)) u_gen (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_start),
    .i_step  (r_state == CHECK),
    .o_a     (w_a),
    .o_b     (w_b),
    .o_cin   (w_cin),
    .o_last  (w_last)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_settle <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_pass <= 1'b0;
      r_err_cnt <= '0;
      r_vec_cnt <= '0;
      r_fev <= 1'b0;
      r_fe_a <= '0;
      r_fe_b <= '0;
      r_fe_cin <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: if (start) begin
          r_state <= APPLY;
          r_settle <= '0;
          r_busy <= 1'b1;
          r_done <= 1'b0;
          r_pass <= 1'b0;
          r_err_cnt <= '0;
          r_vec_cnt <= '0;
          r_fev <= 1'b0;
          r_fe_a <= '0;
          r_fe_b <= '0;
          r_fe_cin <= 1'b0;
        end
        APPLY: begin
          r_settle <= r_settle == SETTLE_LAST ? '0 : r_settle + 1'b1;
          if (r_settle == SETTLE_LAST) r_state <= CHECK;
        end
        CHECK: begin
          r_err_cnt <= w_err_nxt;
          if (r_vec_cnt != N_VEC) r_vec_cnt <= r_vec_cnt + 16'd1;
          if (w_miss && !r_fev) begin
            r_fev <= 1'b1;
            r_fe_a <= w_a;
            r_fe_b <= w_b;
            r_fe_cin <= w_cin;
          end
          r_state <= w_last ? DONE : APPLY;
          // pass uses this cycle's count so the final vector is included
          if (w_last) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
            r_pass <= w_err_nxt == 8'd0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign a_o = w_a;
  assign b_o = w_b;
  assign cin_o = w_cin;
  assign busy = r_busy;
  assign done = r_done;
  assign pass = r_pass;
  assign err_cnt = r_err_cnt;
  assign vec_cnt = r_vec_cnt;
  assign first_err_valid = r_fev;
  assign first_err_a = r_fe_a;
  assign first_err_b = r_fe_b;
  assign first_err_cin = r_fe_cin;
endmodule

// File: tb/tb_adder_sweep_checker.sv
// tb_adder_sweep_checker: drives the checker against ideal and faulty adder models
module tb_adder_sweep_checker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic start3 = 1'b0;
  int mode = 0;
  logic [199:0] bad = '0;
  int checks = 0;
  int failures = 0;
  logic [3:0] a_o, b_o, s_i, fe_a, fe_b;
  logic cin_o, cout_i, busy, done, pass, fev, fe_cin;
  logic [7:0] err_cnt;
  logic [15:0] vec_cnt;
  logic [3:0] a3, b3, s3, fe_a3, fe_b3;
  logic cin3, cout3, busy3, done3, pass3, fev3, fe_cin3;
  logic [7:0] err3;
  logic [15:0] vec3;
  always #5 clk = ~clk;
  // mode 0 ideal, 1 cout stuck 0, 2 s[0] stuck 0, 3 s[0] flipped on vectors flagged in bv
  function automatic logic [4:0] adder_model(input logic [3:0] a, input logic [3:0] b, input logic c,
                                             input int m, input logic [199:0] bv);
    int sum;
    int idx;
    sum = int'(a) + int'(b) + int'(c);
    idx = int'(c) * 100 + int'(a) * 10 + int'(b);
    if (m == 1) sum = sum % 16;
    if (m == 2) sum = sum - (sum % 2);
    if (m == 3 && idx < 200 && bv[idx]) sum = sum ^ 1;
    return 5'(sum);
  endfunction
  assign {cout_i, s_i} = adder_model(a_o, b_o, cin_o, mode, bad);
  assign {cout3, s3} = adder_model(a3, b3, cin3, 0, '0);
  adder_sweep_checker dut (
    .clk(clk), .rst(rst), .start(start), .a_o(a_o), .b_o(b_o), .cin_o(cin_o), .s_i(s_i), .cout_i(cout_i),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .vec_cnt(vec_cnt), .first_err_valid(fev),
    .first_err_a(fe_a), .first_err_b(fe_b), .first_err_cin(fe_cin)
  );
  adder_sweep_checker #(.SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .a_o(a3), .b_o(b3), .cin_o(cin3), .s_i(s3), .cout_i(cout3),
    .busy(busy3), .done(done3), .pass(pass3), .err_cnt(err3), .vec_cnt(vec3), .first_err_valid(fev3),
    .first_err_a(fe_a3), .first_err_b(fe_b3), .first_err_cin(fe_cin3)
  );
  task automatic model_expect(input int m, input logic [199:0] bv, output int n, output int fa,
                              output int fb, output int fc);
    logic [4:0] got;
    n = 0; fa = 0; fb = 0; fc = 0;
    for (int c = 0; c < 2; c++)
      for (int a = 0; a < 10; a++)
        for (int b = 0; b < 10; b++) begin
          got = adder_model(4'(a), 4'(b), 1'(c), m, bv);
          if (int'(got) != a + b + c) begin
            if (n == 0) begin fa = a; fb = b; fc = c; end
            n++;
          end
        end
    if (n > 255) n = 255;
  endtask
  task automatic run_sweep(output int cyc);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (!done && cyc < 2000) begin @(negedge clk); cyc++; end
    if (!done) cyc = -1;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, pass, fev, err_cnt, vec_cnt, a_o, b_o, cin_o, fe_a, fe_b, fe_cin} !== '0) begin
      failures++;
      $display("FAIL reset_state: busy=%b done=%b pass=%b err=%0d vec=%0d a=%0d b=%0d cin=%b, want all 0",
               busy, done, pass, err_cnt, vec_cnt, a_o, b_o, cin_o);
    end
    checks++;
    if ({busy3, done3, pass3, fev3, err3, vec3, a3, b3, cin3} !== '0) begin
      failures++;
      $display("FAIL reset_state_settle3: busy=%b done=%b vec=%0d, want all 0", busy3, done3, vec3);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_ideal;
    int cyc;
    int idx;
    mode = 0; bad = '0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL ideal_busy_start: busy=%b done=%b, want busy=1 done=0", busy, done);
    end
    cyc = 0;
    while (!done && cyc < 2000) begin
      idx = cyc / 2;
      checks++;
      if (cyc < 400 && (int'(vec_cnt) != idx || int'(cin_o) != idx / 100 ||
                        int'(a_o) != (idx % 100) / 10 || int'(b_o) != idx % 10)) begin
        failures++;
        $display("FAIL ideal_track cyc=%0d: vec=%0d a=%0d b=%0d cin=%b, want vec=%0d a=%0d b=%0d cin=%0d",
                 cyc, vec_cnt, a_o, b_o, cin_o, idx, (idx % 100) / 10, idx % 10, idx / 100);
      end
      @(negedge clk); cyc++;
    end
    checks++;
    if (cyc != 400) begin failures++; $display("FAIL ideal_duration: got %0d cycles, want 400", cyc); end
    checks++;
    if (pass !== 1'b1 || busy !== 1'b0 || err_cnt !== 8'd0 || vec_cnt !== 16'd200 || fev !== 1'b0) begin
      failures++;
      $display("FAIL ideal_result: pass=%b busy=%b err=%0d vec=%0d fev=%b, want 1 0 0 200 0",
               pass, busy, err_cnt, vec_cnt, fev);
    end
    checks++;
    if (a_o !== 4'd9 || b_o !== 4'd9 || cin_o !== 1'b1) begin
      failures++;
      $display("FAIL ideal_hold: a=%0d b=%0d cin=%b, want 9 9 1", a_o, b_o, cin_o);
    end
  endtask
  task automatic test_fault(input int m);
    int n, fa, fb, fc, cyc;
    mode = m;
    model_expect(mode, bad, n, fa, fb, fc);
    run_sweep(cyc);
    checks++;
    if (cyc != 400) begin failures++; $display("FAIL fault%0d_duration: got %0d cycles, want 400", m, cyc); end
    checks++;
    if (int'(err_cnt) != n || pass !== (n == 0) || fev !== (n > 0) || vec_cnt !== 16'd200) begin
      failures++;
      $display("FAIL fault%0d_counts: err=%0d pass=%b fev=%b vec=%0d, want err=%0d pass=%0d fev=%0d vec=200",
               m, err_cnt, pass, fev, vec_cnt, n, n == 0, n > 0);
    end
    if (n > 0) begin
      checks++;
      if (int'(fe_a) != fa || int'(fe_b) != fb || int'(fe_cin) != fc) begin
        failures++;
        $display("FAIL fault%0d_first_err: a=%0d b=%0d cin=%b, want a=%0d b=%0d cin=%0d",
                 m, fe_a, fe_b, fe_cin, fa, fb, fc);
      end
    end
  endtask
  task automatic test_random_faults;
    for (int it = 0; it < 3; it++) begin
      bad = '0;
      for (int k = $urandom_range(1, 12); k > 0; k--) bad[$urandom_range(0, 199)] = 1'b1;
      test_fault(3);
    end
  endtask
  task automatic test_back_to_back;
    int cyc;
    mode = 0; bad = '0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    checks++;
    if (done !== 1'b0 || pass !== 1'b0 || busy !== 1'b1 || err_cnt !== 8'd0 || vec_cnt !== 16'd0 || fev !== 1'b0) begin
      failures++;
      $display("FAIL restart_clear: done=%b pass=%b busy=%b err=%0d vec=%0d fev=%b, want 0 0 1 0 0 0",
               done, pass, busy, err_cnt, vec_cnt, fev);
    end
    cyc = 0;
    while (!done && cyc < 2000) begin
      start = (cyc == 100);
      @(negedge clk); cyc++;
    end
    start = 1'b0;
    checks++;
    if (cyc != 400 || pass !== 1'b1 || vec_cnt !== 16'd200) begin
      failures++;
      $display("FAIL busy_start_ignored: cycles=%0d pass=%b vec=%0d, want 400 1 200", cyc, pass, vec_cnt);
    end
    run_sweep(cyc);
    checks++;
    if (cyc != 400 || pass !== 1'b1 || err_cnt !== 8'd0 || vec_cnt !== 16'd200 || fev !== 1'b0) begin
      failures++;
      $display("FAIL second_sweep: cycles=%0d pass=%b err=%0d vec=%0d fev=%b, want 400 1 0 200 0",
               cyc, pass, err_cnt, vec_cnt, fev);
    end
  endtask
  task automatic test_mid_reset;
    mode = 2;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (50) @(negedge clk);
    checks++;
    if (err_cnt === 8'd0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_sweep_state: err=%0d busy=%b, want err>0 busy=1", err_cnt, busy);
    end
    rst = 1'b1; start = 1'b1;
    @(negedge clk); rst = 1'b0; start = 1'b0;
    checks++;
    if ({busy, done, pass, fev, err_cnt, vec_cnt, a_o, b_o, cin_o} !== '0) begin
      failures++;
      $display("FAIL mid_reset: busy=%b done=%b err=%0d vec=%0d a=%0d b=%0d cin=%b, want all 0",
               busy, done, err_cnt, vec_cnt, a_o, b_o, cin_o);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || vec_cnt !== 16'd0 || {a_o, b_o, cin_o} !== '0) begin
      failures++;
      $display("FAIL idle_after_reset: busy=%b done=%b vec=%0d, want idle", busy, done, vec_cnt);
    end
  endtask
  task automatic test_settle3;
    int cyc, run, changes;
    logic [8:0] prev;
    @(negedge clk); start3 = 1'b1;
    @(negedge clk); start3 = 1'b0;
    prev = {a3, b3, cin3};
    cyc = 0; run = 1; changes = 0;
    while (!done3 && cyc < 4000) begin
      @(negedge clk); cyc++;
      if ({a3, b3, cin3} != prev) begin
        checks++;
        if (run != 4) begin
          failures++;
          $display("FAIL settle3_hold cyc=%0d: operand held %0d cycles, want 4", cyc, run);
        end
        changes++; run = 1; prev = {a3, b3, cin3};
      end else run++;
    end
    checks++;
    if (cyc != 800 || changes != 199) begin
      failures++;
      $display("FAIL settle3_duration: cycles=%0d changes=%0d, want 800 199", cyc, changes);
    end
    checks++;
    if (pass3 !== 1'b1 || err3 !== 8'd0 || vec3 !== 16'd200 || busy3 !== 1'b0) begin
      failures++;
      $display("FAIL settle3_result: pass=%b err=%0d vec=%0d busy=%b, want 1 0 200 0", pass3, err3, vec3, busy3);
    end
  endtask
  initial begin
    test_reset;
    test_ideal;
    test_fault(1);
    test_fault(2);
    test_random_faults;
    test_back_to_back;
    test_mid_reset;
    test_settle3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
